// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS32 ALU-control decode stage.
// Holds the ALU operation encodings, the opcode/funct constants the decoder
// matches against, the default control width and the decoder result struct.
package alu_pkg;

  localparam int unsigned CTRL_W_DEFAULT = 4;

  // ALU operation encodings (low 4 bits of alu_ctrl)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_MULT = 4'b1100;
  localparam logic [3:0] ALU_DIV  = 4'b1101;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef struct packed {
    logic [3:0] op;
    logic       illegal;
    logic       is_mult;
    logic       is_div;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Decode-side / execute-side handshake bundle of the ALU-control stage.
//   in_valid, instr    upstream -> stage     in_ready           stage -> upstream
//   out_ready          downstream -> stage   out_valid, alu_ctrl, illegal, md_busy -> downstream
// master: the environment around the stage; slave: the stage itself.
interface alu_ctrl_stage_if #(
  parameter int unsigned ALUCTRL_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic                 illegal;
  logic                 md_busy;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_ctrl, illegal, md_busy
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_ctrl, illegal, md_busy
  );
endinterface

// File: rtl/alu_op_decode.sv
// Pure combinational MIPS32 ALU-control decoder.
//   instr    in   32  instruction word (opcode [31:26], funct [5:0])
//   dec      out      {op, illegal, is_mult, is_div}
// Opcode is matched first; funct only matters for R-type (opcode 000000).
// Anything not in the table decodes as ADD with illegal set.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    dec.op      = ALU_ADD;
    dec.illegal = 1'b0;
    dec.is_mult = 1'b0;
    dec.is_div  = 1'b0;
    case (opcode)
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: dec.op = ALU_ADD;
      OP_BEQ, OP_BNE:                  dec.op = ALU_SUB;
      OP_SLTI:                         dec.op = ALU_SLT;
      OP_SLTIU:                        dec.op = ALU_SLTU;
      OP_ANDI:                         dec.op = ALU_AND;
      OP_ORI:                          dec.op = ALU_OR;
      OP_XORI:                         dec.op = ALU_XOR;
      OP_LUI:                          dec.op = ALU_LUI;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU:   dec.op = ALU_ADD;
          FN_SUB, FN_SUBU:   dec.op = ALU_SUB;
          FN_AND:            dec.op = ALU_AND;
          FN_OR:             dec.op = ALU_OR;
          FN_XOR:            dec.op = ALU_XOR;
          FN_NOR:            dec.op = ALU_NOR;
          FN_SLT:            dec.op = ALU_SLT;
          FN_SLTU:           dec.op = ALU_SLTU;
          FN_SLL:            dec.op = ALU_SLL;
          FN_SRL:            dec.op = ALU_SRL;
          FN_SRA:            dec.op = ALU_SRA;
          FN_MULT, FN_MULTU: begin
            dec.op      = ALU_MULT;
            dec.is_mult = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            dec.op     = ALU_DIV;
            dec.is_div = 1'b1;
          end
          default:           dec.illegal = 1'b1;
        endcase
      end
      default:                         dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered, handshaked ALU-control decode stage with a mult/div busy sequencer.
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of alu_ctrl_stage_if:
//         in_valid/in_ready/instr (decode side), out_valid/out_ready/alu_ctrl/illegal
//         (execute side), md_busy (mult/div unit occupied)
// A MULT/DIV accept loads a down-counter; while it is non-zero the stage refuses
// new instructions, back-pressuring fetch/decode.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned DIV_LAT   = 32,
  parameter int unsigned CNT_W     = 6
) (
  input logic               clk,
  input logic               rst,
  alu_ctrl_stage_if.slave   bus
);

  dec_t                 dec;
  logic                 accept;
  logic                 md_busy;
  logic                 out_valid_q, out_valid_d;
  logic                 illegal_q, illegal_d;
  logic [ALUCTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]     md_cnt_q, md_cnt_d;

  alu_op_decode u_dec (
    .instr (bus.instr),
    .dec   (dec)
  );

  assign md_busy      = (md_cnt_q != '0);
  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !md_busy;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    md_cnt_d    = md_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      ctrl_d      = ALUCTRL_W'(dec.op);
      illegal_d   = dec.illegal;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // is_mult/is_div are never set for illegal instructions
    if (accept && dec.is_mult) begin
      md_cnt_d = CNT_W'(MUL_LAT);
    end else if (accept && dec.is_div) begin
      md_cnt_d = CNT_W'(DIV_LAT);
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      md_cnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_busy   = md_busy;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: stimulus pushes the expected {alu_ctrl, illegal}
// on every accept; a monitor pops and compares on every out_valid & out_ready cycle.
module tb_alu_ctrl_stage;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 32;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] exp_q[$];

  alu_ctrl_stage_if #(.ALUCTRL_W(4)) bus ();

  alu_ctrl_stage #(
    .ALUCTRL_W (4),
    .MUL_LAT   (MUL_LAT),
    .DIV_LAT   (DIV_LAT),
    .CNT_W     (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one consumed output per cycle where out_valid & out_ready
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", {bus.alu_ctrl, bus.illegal});
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("scoreboard_ctrl_illegal", {27'd0, bus.alu_ctrl, bus.illegal}, {27'd0, e});
      end
    end
  end

  // Present instr and hold in_valid until accepted; returns how many cycles it waited.
  // Entered and left at posedge+1; in_valid stays high on return.
  task automatic send(input logic [31:0] ins, input logic [3:0] ctrl, input logic ill,
                      output int waits);
    bit done;
    done         = 1'b0;
    waits        = 0;
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({ctrl, ill});
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted instr=%h", ins);
    end
  endtask

  logic [31:0] stream_instr [14] = '{
    32'h00851022, 32'h38A40005, 32'h00052083, 32'h3C041234,
    32'h8C850004, 32'h10850003, 32'h00851027, 32'h00052080,
    32'h00052082, 32'h30A4000F, 32'h34A4000F, 32'h2CA4000F,
    32'h0085102B, 32'h00851025
  };
  logic [3:0] stream_ctrl [14] = '{
    4'b0110, 4'b0011, 4'b1010, 4'b1011,
    4'b0010, 4'b0110, 4'b0100, 4'b1000,
    4'b1001, 4'b0000, 4'b0001, 4'b0101,
    4'b0101, 4'b0001
  };

  initial begin
    int w;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h00851020;
    bus.out_ready = 1'b1;

    // Reset held with a valid add waiting
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back({4'b0010, 1'b0});
    @(posedge clk);
    #1;
    chk("first_out_valid", 32'(bus.out_valid), 32'd1);
    chk("first_alu_ctrl", 32'(bus.alu_ctrl), 32'b0010);

    // Back-to-back stream: each accepted without waiting
    for (int i = 0; i < 14; i++) begin
      send(stream_instr[i], stream_ctrl[i], 1'b0, w);
      chk("stream_no_bubble", 32'(w), 32'd0);
    end

    // Stall: slt held while out_ready low, next instr pending
    send(32'h0085102A, 4'b0111, 1'b0, w);
    bus.out_ready = 1'b0;
    bus.instr     = 32'h00851020;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_alu_ctrl", 32'(bus.alu_ctrl), 32'b0111);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'h00851020, 4'b0010, 1'b0, w);
    chk("release_same_cycle", 32'(w), 32'd0);

    // MULT busy window
    send(32'h00850018, 4'b1100, 1'b0, w);
    bus.in_valid = 1'b0;
    for (int i = 0; i < int'(MUL_LAT); i++) begin
      @(negedge clk);
      chk("mult_busy", 32'(bus.md_busy), 32'd1);
      chk("mult_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    chk("mult_done_busy", 32'(bus.md_busy), 32'd0);
    chk("mult_done_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // DIV busy window
    send(32'h0085001A, 4'b1101, 1'b0, w);
    bus.in_valid = 1'b0;
    for (int i = 0; i < int'(DIV_LAT); i++) begin
      @(negedge clk);
      chk("div_busy", 32'(bus.md_busy), 32'd1);
    end
    @(negedge clk);
    chk("div_done_busy", 32'(bus.md_busy), 32'd0);
    @(posedge clk);
    #1;

    // Illegal opcode, illegal funct, and a non-R opcode whose funct field looks like mult
    send(32'hFC000000, 4'b0010, 1'b1, w);
    send(32'h0085003F, 4'b0010, 1'b1, w);
    send(32'h20A40018, 4'b0010, 1'b0, w);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("illegal_no_busy", 32'(bus.md_busy), 32'd0);
    end
    @(posedge clk);
    #1;

    // Async reset in the middle of a div, with the div output still unconsumed
    send(32'h0085001A, 4'b1101, 1'b0, w);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("div_mid_busy", 32'(bus.md_busy), 32'd1);
    chk("div_mid_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_busy", 32'(bus.md_busy), 32'd0);
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rerst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(32'h00851027, 4'b0100, 1'b0, w);
    chk("rerst_accept", 32'(w), 32'd0);
    bus.in_valid = 1'b0;

    // Drain scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
